// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and requester indices shared by the memory port arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;
endpackage

// File: rtl/mux2_1.sv
// mux2_1: two-input multiplexer, sel=0 passes data_in1, sel=1 passes data_in2
module mux2_1 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data_in1,
   input  logic [DATA_WIDTH-1:0] data_in2,
   input  logic                  sel,
   output logic [DATA_WIDTH-1:0] data_out
);
   assign data_out = sel ? data_in2 : data_in1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the unified memory port between fetch and load/store
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  owner,
   output logic                  busy
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   state_t r_state, w_next;
   logic r_owner, r_last_owner, r_err, w_owner_next, w_timeout, w_we;
   logic [CW-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] r_rdata;

   assign w_timeout = (r_cnt == LAST_CNT);

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   end

   // Next state and round-robin grant; a tie goes to whoever was not served last
   always_comb begin
      w_next = r_state;
      w_owner_next = r_owner;
      unique case (r_state)
         IDLE: if (req0 || req1) begin
            w_next = BUSY;
            w_owner_next = (req0 && req1) ? ~r_last_owner : (req1 ? REQ_DATA : REQ_FETCH);
         end
         BUSY: if (mem_ready || w_timeout) w_next = DONE;
         DONE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Owner, wait counter and response capture; mem_ready beats a coinciding timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner      <= REQ_FETCH;
         r_last_owner <= REQ_DATA;
         r_cnt        <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         r_owner <= w_owner_next;
         if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (mem_ready) begin
               r_rdata <= mem_rdata;
               r_err   <= 1'b0;
            end else if (w_timeout) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
         if (r_state == DONE) begin
            r_last_owner <= r_owner;
            r_cnt        <= '0;
         end
      end
   end

   mux2_1 #(.DATA_WIDTH(ADDR_WIDTH)) u_addr_mux (
      .data_in1(addr0), .data_in2(addr1), .sel(r_owner), .data_out(mem_addr)
   );
   mux2_1 #(.DATA_WIDTH(DATA_WIDTH)) u_wdata_mux (
      .data_in1(wdata0), .data_in2(wdata1), .sel(r_owner), .data_out(mem_wdata)
   );
   mux2_1 #(.DATA_WIDTH(1)) u_we_mux (
      .data_in1(we0), .data_in2(we1), .sel(r_owner), .data_out(w_we)
   );

   assign busy    = (r_state != IDLE);
   assign mem_req = (r_state == BUSY);
   assign mem_we  = mem_req & w_we;
   assign ack0    = (r_state == DONE) && (r_owner == REQ_FETCH);
   assign ack1    = (r_state == DONE) && (r_owner == REQ_DATA);
   assign err     = (r_state == DONE) && r_err;
   assign rdata   = r_rdata;
   assign owner   = r_owner;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle MIPS core between two requesters: requester 0 is instruction fetch, requester 1 is load/store data.
- Round-robin arbitration, one outstanding transaction at a time, with a watchdog timeout on the memory response.
- Drives the select of two mux2_1 instances (address and write-data steering) and routes the response back to the owning requester.
- Sits between the fetch/LSU control and the memory wrapper.

Parameters:
ADDR_WIDTH, 32, width of addr0/addr1/mem_addr
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT, 16, max BUSY cycles without mem_ready before error completion (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req0  input  1  fetch request, held until ack0
we0  input  1  fetch write enable (normally 0)
addr0  input  ADDR_WIDTH  fetch address
wdata0  input  DATA_WIDTH  fetch write data
req1  input  1  data request, held until ack1
we1  input  1  data write enable
addr1  input  ADDR_WIDTH  data address
wdata1  input  DATA_WIDTH  data write data
ack0  output  1  one-cycle completion pulse to requester 0
ack1  output  1  one-cycle completion pulse to requester 1
err  output  1  one-cycle pulse with ack: completion was a timeout
rdata  output  DATA_WIDTH  registered read data, valid while ack0/ack1 high
mem_req  output  1  memory transaction active
mem_we  output  1  memory write enable, qualified by mem_req
mem_addr  output  ADDR_WIDTH  memory address (mux2_1 output)
mem_wdata  output  DATA_WIDTH  memory write data (mux2_1 output)
mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  input  1  memory completes the transaction this cycle
owner  output  1  current/last granted requester; drives both mux selects
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low. On a clock edge with rst_n=0, all registers reset.
- Reset values:
  - state=IDLE, owner=0, last_owner=1 (so requester 0 wins the first tie), wait counter=0, rdata=0.
  - ack0=ack1=err=mem_req=mem_we=busy=0.
  - mem_addr/mem_wdata show the requester-0 inputs through the mux. They are don't-care while mem_req=0.
- Reset mid-transaction abandons the transaction. No ack is issued and the memory sees mem_req fall.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If exactly one req is high, register owner to that index and go to BUSY.
  - If both are high, owner = ~last_owner, then go to BUSY.
  - If neither is high, stay in IDLE.
- BUSY:
  - mem_req=1 and mem_we = selected we.
  - Address and write data come from the muxes with sel=owner.
  - The wait counter increments each BUSY cycle.
  - mem_ready=1: capture mem_rdata into rdata, go to DONE with err=0.
  - mem_ready=0 with counter==TIMEOUT-1: rdata=0, go to DONE with err=1.
  - If mem_ready and timeout coincide, mem_ready wins and err=0.
- DONE:
  - ack[owner]=1 for exactly this cycle; err is valid this cycle.
  - last_owner<=owner and the counter clears.
  - req inputs are ignored; always return to IDLE.
- Requester rule: req is dropped on the edge that samples ack=1. The re-evaluation in IDLE therefore sees fresh requests only.
- mem_ready outside BUSY is ignored.
- Latency: req sampled at edge k puts mem_req high in cycle k+1. Zero-wait memory (mem_ready in that same cycle) gives ack in cycle k+2. Minimum transaction period is 3 cycles.
- Address, data and we changes from a requester while it owns the port are the requester's fault. The arbiter forwards them combinationally; it does not latch them.
- ack0 and ack1 are never high together; the outputs are mutually exclusive by construction.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - requester index constants: REQ_FETCH=1'b0, REQ_DATA=1'b1.
- Sub-modules: reuse the existing mux2_1 twice, with DATA_WIDTH=ADDR_WIDTH for the address and DATA_WIDTH for the write data, plus one 1-bit instance for we. Inputs are data_in1 = requester 0, data_in2 = requester 1, sel=owner.
- No new sub-module is needed; the arbitration and timer logic stay in this module.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req0=req1=1 -> ack0=ack1=err=mem_req=busy=0, rdata=0, owner=0.
2. Single fetch: req0=1, addr0=0x0000_0040, memory returns 0x2108_0001 with mem_ready one cycle after mem_req rises -> mem_addr=0x40, mem_we=0, ack0 pulses 1 cycle with rdata=0x2108_0001, err=0, ack1 never asserts.
3. Simultaneous contention: req0=req1=1 continuously (each re-raised after ack), zero-wait memory -> grants alternate 0,1,0,1. Each ack is 3 cycles apart; no requester is granted twice in a row.
4. Data store: req1=1, we1=1, addr1=0x1000_0008, wdata1=0xDEAD_BEEF -> mem_we=1, mem_addr=0x1000_0008, mem_wdata=0xDEAD_BEEF during BUSY; ack1 pulses after mem_ready.
5. Timeout: req0=1, mem_ready held 0 -> exactly TIMEOUT=16 BUSY cycles, then ack0=1 with err=1 and rdata=0. Next request proceeds normally. Variant: mem_ready on the 16th BUSY cycle -> err=0, captured data returned.
6. Reset mid-operation: assert rst_n=0 in the 3rd BUSY cycle -> mem_req=0 the next cycle, no ack, owner=0. After release, a pending req1 is granted normally.
